// File: rtl/wb_downsizer_pkg.sv
// ---------------------------------------------------------------------------
// wb_downsizer_pkg
// Shared definitions for the wide-to-narrow Wishbone bridge:
//   state_t    - bridge sequencing states (IDLE / BEAT / DONE)
//   resp_t     - upstream response kind returned in DONE
//   pick_resp  - resolves a simultaneous narrow err/rty (err wins)
//   idx_width  - width of a beat index for a given beat count
// ---------------------------------------------------------------------------
package wb_downsizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RESP_ACK = 2'd0,
        RESP_ERR = 2'd1,
        RESP_RTY = 2'd2
    } resp_t;

    // Error has priority over retry when a slave raises both at once.
    function automatic resp_t pick_resp(input logic err, input logic rty);
        if (err) begin
            return RESP_ERR;
        end else if (rty) begin
            return RESP_RTY;
        end
        return RESP_ACK;
    endfunction

    // A single-beat configuration still needs a 1-bit index to stay legal.
    function automatic int idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/wb_next_beat.sv
// ---------------------------------------------------------------------------
// wb_next_beat
// Combinational priority encoder that finds the next narrow beat whose
// byte-select slice is nonzero.
//   sel       in  byte selects of the whole wide transfer
//   cur_idx   in  beat currently being served
//   first     in  1: search from beat 0 inclusive; 0: search above cur_idx
//   next_idx  out lowest qualifying beat index
//   none_left out no qualifying beat exists
// ---------------------------------------------------------------------------
module wb_next_beat #(
    parameter int BEATS    = 4,
    parameter int LANE_SEL = 4,
    parameter int IDXW     = 2
) (
    input  logic [BEATS*LANE_SEL-1:0] sel,
    input  logic [IDXW-1:0]           cur_idx,
    input  logic                      first,
    output logic [IDXW-1:0]           next_idx,
    output logic                      none_left
);

    logic [BEATS-1:0] lane_any;

    always_comb begin
        lane_any = '0;
        for (int i = 0; i < BEATS; i++) begin
            lane_any[i] = |sel[i*LANE_SEL +: LANE_SEL];
        end
    end

    // Scanning downwards lets the lowest qualifying beat be the last write.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (lane_any[i] && (first || (i > int'(cur_idx)))) begin
                next_idx  = IDXW'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_downsizer.sv
// ---------------------------------------------------------------------------
// wb_downsizer
// Wishbone classic bridge: splits one WIDE_WIDTH transfer into sequential
// NARROW_WIDTH beats, skipping beats with no byte selects, and reassembles
// narrow read data into one wide response. Narrow err/rty end the transfer
// and are forwarded upstream. All outputs are registered.
//   clk, rst                       clock, synchronous active-high reset
//   s_adr_i/s_dat_i/s_we_i/s_sel_i upstream request (wide)
//   s_stb_i/s_cyc_i                upstream handshake
//   s_dat_o/s_ack_o/s_err_o/s_rty_o upstream response
//   m_adr_o/m_dat_o/m_we_o/m_sel_o narrow request
//   m_stb_o/m_cyc_o                narrow handshake
//   m_dat_i/m_ack_i/m_err_i/m_rty_i narrow response
// ---------------------------------------------------------------------------
module wb_downsizer
    import wb_downsizer_pkg::*;
#(
    parameter int WIDE_WIDTH   = 128,
    parameter int NARROW_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     s_adr_i,
    input  logic [WIDE_WIDTH-1:0]     s_dat_i,
    output logic [WIDE_WIDTH-1:0]     s_dat_o,
    input  logic                      s_we_i,
    input  logic [WIDE_WIDTH/8-1:0]   s_sel_i,
    input  logic                      s_stb_i,
    input  logic                      s_cyc_i,
    output logic                      s_ack_o,
    output logic                      s_err_o,
    output logic                      s_rty_o,
    output logic [ADDR_WIDTH-1:0]     m_adr_o,
    output logic [NARROW_WIDTH-1:0]   m_dat_o,
    input  logic [NARROW_WIDTH-1:0]   m_dat_i,
    output logic                      m_we_o,
    output logic [NARROW_WIDTH/8-1:0] m_sel_o,
    output logic                      m_stb_o,
    output logic                      m_cyc_o,
    input  logic                      m_ack_i,
    input  logic                      m_err_i,
    input  logic                      m_rty_i
);

    localparam int BEATS    = WIDE_WIDTH / NARROW_WIDTH;
    localparam int NB       = NARROW_WIDTH / 8;
    localparam int WSEL     = WIDE_WIDTH / 8;
    localparam int IDXW     = idx_width(BEATS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WSEL - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP  = ADDR_WIDTH'(NB);

    state_t                  state;
    logic [IDXW-1:0]         idx_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [WIDE_WIDTH-1:0]   dat_q;
    logic                    we_q;
    logic [WSEL-1:0]         sel_q;
    logic [WIDE_WIDTH-1:0]   rbuf;

    logic [WSEL-1:0]         enc_sel;
    logic                    enc_first;
    logic [IDXW-1:0]         next_idx;
    logic                    none_left;
    logic [WIDE_WIDTH-1:0]   merged;
    logic [ADDR_WIDTH-1:0]   req_base;
    resp_t                   beat_resp;

    // In IDLE the request is not latched yet, so the encoder looks at the
    // live selects and searches from beat 0; afterwards it walks sel_q.
    always_comb begin
        enc_sel   = sel_q;
        enc_first = 1'b0;
        if (state == ST_IDLE) begin
            enc_sel   = s_sel_i;
            enc_first = 1'b1;
        end
    end

    wb_next_beat #(
        .BEATS    (BEATS),
        .LANE_SEL (NB),
        .IDXW     (IDXW)
    ) u_next_beat (
        .sel       (enc_sel),
        .cur_idx   (idx_q),
        .first     (enc_first),
        .next_idx  (next_idx),
        .none_left (none_left)
    );

    // Read buffer including the beat being acknowledged this cycle, so the
    // final beat's data lands in s_dat_o without an extra cycle.
    always_comb begin
        merged = rbuf;
        if (!we_q) begin
            merged[int'(idx_q)*NARROW_WIDTH +: NARROW_WIDTH] = m_dat_i;
        end
        req_base  = s_adr_i & ALIGN_MASK;
        beat_resp = pick_resp(m_err_i, m_rty_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rbuf    <= '0;
            s_dat_o <= '0;
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_rty_o <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            m_stb_o <= 1'b0;
            m_cyc_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_cyc_i && s_stb_i) begin
                        adr_q <= req_base;
                        dat_q <= s_dat_i;
                        we_q  <= s_we_i;
                        sel_q <= s_sel_i;
                        rbuf  <= '0;
                        if (none_left) begin
                            state   <= ST_DONE;
                            s_ack_o <= 1'b1;
                            s_dat_o <= '0;
                        end else begin
                            state   <= ST_BEAT;
                            idx_q   <= next_idx;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= s_we_i;
                            m_adr_o <= req_base + ADDR_WIDTH'(next_idx) * BEAT_STEP;
                            m_dat_o <= s_dat_i[int'(next_idx)*NARROW_WIDTH +: NARROW_WIDTH];
                            m_sel_o <= s_sel_i[int'(next_idx)*NB +: NB];
                        end
                    end
                end

                ST_BEAT: begin
                    if (!s_cyc_i) begin
                        // Master abandoned the cycle: drop the bus silently.
                        state   <= ST_IDLE;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                    end else if (m_err_i || m_rty_i) begin
                        state   <= ST_DONE;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        s_err_o <= (beat_resp == RESP_ERR);
                        s_rty_o <= (beat_resp == RESP_RTY);
                        s_dat_o <= rbuf;
                    end else if (m_ack_i) begin
                        rbuf <= merged;
                        if (none_left) begin
                            state   <= ST_DONE;
                            m_cyc_o <= 1'b0;
                            m_stb_o <= 1'b0;
                            s_ack_o <= 1'b1;
                            s_dat_o <= merged;
                        end else begin
                            idx_q   <= next_idx;
                            m_adr_o <= adr_q + ADDR_WIDTH'(next_idx) * BEAT_STEP;
                            m_dat_o <= dat_q[int'(next_idx)*NARROW_WIDTH +: NARROW_WIDTH];
                            m_sel_o <= sel_q[int'(next_idx)*NB +: NB];
                        end
                    end
                end

                ST_DONE: begin
                    // Response is a one-cycle pulse; inputs are not looked at.
                    state   <= ST_IDLE;
                    s_ack_o <= 1'b0;
                    s_err_o <= 1'b0;
                    s_rty_o <= 1'b0;
                    s_dat_o <= '0;
                end

                default: begin
                    state   <= ST_IDLE;
                    m_cyc_o <= 1'b0;
                    m_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_downsizer.sv
// ---------------------------------------------------------------------------
// tb_wb_downsizer
// Directed self-checking bench for wb_downsizer with a small narrow slave
// that can insert wait states on beat 0 and error/retry on a chosen beat.
// ---------------------------------------------------------------------------
module tb_wb_downsizer;

    logic         clk;
    logic         rst;
    logic [31:0]  s_adr_i;
    logic [127:0] s_dat_i;
    logic [127:0] s_dat_o;
    logic         s_we_i;
    logic [15:0]  s_sel_i;
    logic         s_stb_i;
    logic         s_cyc_i;
    logic         s_ack_o;
    logic         s_err_o;
    logic         s_rty_o;
    logic [31:0]  m_adr_o;
    logic [31:0]  m_dat_o;
    logic [31:0]  m_dat_i;
    logic         m_we_o;
    logic [3:0]   m_sel_o;
    logic         m_stb_o;
    logic         m_cyc_o;
    logic         m_ack_i;
    logic         m_err_i;
    logic         m_rty_i;

    int compared   = 0;
    int mismatched = 0;

    // Slave configuration and observation log
    int          wait_beat0 = 0;
    int          err_beat   = -1;
    int          rty_beat   = -1;
    int          wait_cnt   = 0;
    int          stb_cycles = 0;
    int          beat0_cycles = 0;
    int          log_n      = 0;
    logic [31:0] log_adr [0:15];
    logic [31:0] log_dat [0:15];
    logic [3:0]  log_sel [0:15];
    logic        log_we  [0:15];

    wb_downsizer #(
        .WIDE_WIDTH   (128),
        .NARROW_WIDTH (32),
        .ADDR_WIDTH   (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_adr_i (s_adr_i),
        .s_dat_i (s_dat_i),
        .s_dat_o (s_dat_o),
        .s_we_i  (s_we_i),
        .s_sel_i (s_sel_i),
        .s_stb_i (s_stb_i),
        .s_cyc_i (s_cyc_i),
        .s_ack_o (s_ack_o),
        .s_err_o (s_err_o),
        .s_rty_o (s_rty_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_stb_o (m_stb_o),
        .m_cyc_o (m_cyc_o),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i),
        .m_rty_i (m_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Narrow slave: decides its response on the falling edge so the bridge
    // sees it at the next rising edge. Read data is 0xA0 + beat number.
    always @(negedge clk) begin
        int beat;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_rty_i = 1'b0;
        if (m_cyc_o && m_stb_o) begin
            stb_cycles++;
            if (m_adr_o == 32'h1000) beat0_cycles++;
            beat = int'(m_adr_o[3:2]);
            if (beat == 0 && wait_cnt < wait_beat0) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (log_n < 16) begin
                    log_adr[log_n] = m_adr_o;
                    log_dat[log_n] = m_dat_o;
                    log_sel[log_n] = m_sel_o;
                    log_we[log_n]  = m_we_o;
                    log_n++;
                end
                if (beat == err_beat) begin
                    m_err_i = 1'b1;
                end else if (beat == rty_beat) begin
                    m_rty_i = 1'b1;
                end else begin
                    m_ack_i = 1'b1;
                    m_dat_i = 32'hA0 + 32'(beat);
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [127:0] got,
                                input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_slave(input int waits, input int eb, input int rb);
        wait_beat0   = waits;
        err_beat     = eb;
        rty_beat     = rb;
        wait_cnt     = 0;
        stb_cycles   = 0;
        beat0_cycles = 0;
        log_n        = 0;
    endtask

    // Issues one upstream request and waits (bounded) for its response.
    // lat counts cycles after the sampling edge; -1 means no response.
    task automatic apply_stimulus(input logic [31:0] adr, input logic [127:0] dat,
                                  input logic we, input logic [15:0] sel,
                                  output int lat, output logic ack,
                                  output logic err, output logic rty,
                                  output logic [127:0] rdat,
                                  output logic resp_after, output logic cyc_after);
        @(negedge clk);
        s_adr_i = adr;
        s_dat_i = dat;
        s_we_i  = we;
        s_sel_i = sel;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        lat  = -1;
        ack  = 1'b0;
        err  = 1'b0;
        rty  = 1'b0;
        rdat = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_ack_o || s_err_o || s_rty_o) begin
                lat  = k;
                ack  = s_ack_o;
                err  = s_err_o;
                rty  = s_rty_o;
                rdat = s_dat_o;
                break;
            end
        end
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        @(negedge clk);
        resp_after = s_ack_o | s_err_o | s_rty_o;
        cyc_after  = m_cyc_o;
    endtask

    initial begin
        int           lat;
        logic         ack, err, rty, resp_after, cyc_after, any_resp, found;
        logic [127:0] rdat;

        rst = 1'b1;
        s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_sel_i = '0;
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_dat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_output("reset_m_cyc", 128'(m_cyc_o), 128'd0);
        check_output("reset_m_stb", 128'(m_stb_o), 128'd0);
        check_output("reset_s_ack", 128'(s_ack_o), 128'd0);
        check_output("reset_s_dat", s_dat_o, 128'd0);
        check_output("reset_m_adr", 128'(m_adr_o), 128'd0);

        // Full read, four beats
        clear_slave(0, -1, -1);
        apply_stimulus(32'h1000, '0, 1'b0, 16'hFFFF, lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("full_lat", 128'(lat), 128'd5);
        check_output("full_ack", 128'(ack), 128'd1);
        check_output("full_dat", rdat, 128'h000000A3_000000A2_000000A1_000000A0);
        check_output("full_beats", 128'(log_n), 128'd4);
        check_output("full_adr0", 128'(log_adr[0]), 128'h1000);
        check_output("full_adr1", 128'(log_adr[1]), 128'h1004);
        check_output("full_adr2", 128'(log_adr[2]), 128'h1008);
        check_output("full_adr3", 128'(log_adr[3]), 128'h100C);
        check_output("full_pulse", 128'(resp_after), 128'd0);
        check_output("full_cyc_after", 128'(cyc_after), 128'd0);

        // Sparse write, beats 0 and 3 only
        clear_slave(0, -1, -1);
        apply_stimulus(32'h1000, 128'h44444444_33333333_22222222_11111111, 1'b1, 16'hF00F,
                       lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("sparse_lat", 128'(lat), 128'd3);
        check_output("sparse_ack", 128'(ack), 128'd1);
        check_output("sparse_beats", 128'(log_n), 128'd2);
        check_output("sparse_adr0", 128'(log_adr[0]), 128'h1000);
        check_output("sparse_dat0", 128'(log_dat[0]), 128'h11111111);
        check_output("sparse_sel0", 128'(log_sel[0]), 128'hF);
        check_output("sparse_we0", 128'(log_we[0]), 128'd1);
        check_output("sparse_adr1", 128'(log_adr[1]), 128'h100C);
        check_output("sparse_dat1", 128'(log_dat[1]), 128'h44444444);
        check_output("sparse_sel1", 128'(log_sel[1]), 128'hF);

        // All-zero selects: no narrow access
        clear_slave(0, -1, -1);
        apply_stimulus(32'h2000, 128'h1, 1'b0, 16'h0000, lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("zero_lat", 128'(lat), 128'd1);
        check_output("zero_ack", 128'(ack), 128'd1);
        check_output("zero_dat", rdat, 128'd0);
        check_output("zero_stb", 128'(stb_cycles), 128'd0);

        // Error on beat 1
        clear_slave(0, 1, -1);
        apply_stimulus(32'h1000, '0, 1'b0, 16'hFFFF, lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("err_lat", 128'(lat), 128'd3);
        check_output("err_flag", 128'(err), 128'd1);
        check_output("err_ack", 128'(ack), 128'd0);
        check_output("err_beats", 128'(log_n), 128'd2);
        check_output("err_pulse", 128'(resp_after), 128'd0);

        // Retry on beat 1
        clear_slave(0, -1, 1);
        apply_stimulus(32'h1000, '0, 1'b0, 16'hFFFF, lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("rty_lat", 128'(lat), 128'd3);
        check_output("rty_flag", 128'(rty), 128'd1);
        check_output("rty_err", 128'(err), 128'd0);
        check_output("rty_ack", 128'(ack), 128'd0);
        check_output("rty_beats", 128'(log_n), 128'd2);

        // Three wait states on beat 0
        clear_slave(3, -1, -1);
        apply_stimulus(32'h1000, '0, 1'b0, 16'hFFFF, lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("wait_lat", 128'(lat), 128'd8);
        check_output("wait_beat0_cycles", 128'(beat0_cycles), 128'd4);
        check_output("wait_stb_cycles", 128'(stb_cycles), 128'd7);
        check_output("wait_dat", rdat, 128'h000000A3_000000A2_000000A1_000000A0);

        // Upstream abort during beat 2
        clear_slave(0, -1, -1);
        @(negedge clk);
        s_adr_i = 32'h1000; s_we_i = 1'b0; s_sel_i = 16'hFFFF;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_stb_o && m_adr_o == 32'h1008) begin
                found = 1'b1;
                break;
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        check_output("abort_reached", 128'(found), 128'd1);
        @(negedge clk);
        check_output("abort_m_cyc", 128'(m_cyc_o), 128'd0);
        any_resp = s_ack_o | s_err_o | s_rty_o;
        repeat (3) begin
            @(negedge clk);
            any_resp = any_resp | s_ack_o | s_err_o | s_rty_o;
        end
        check_output("abort_no_resp", 128'(any_resp), 128'd0);

        // Reset in the middle of a transfer
        clear_slave(0, -1, -1);
        @(negedge clk);
        s_adr_i = 32'h1000; s_we_i = 1'b0; s_sel_i = 16'hFFFF;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_stb_o && m_adr_o == 32'h1004) begin
                found = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        check_output("rst_reached", 128'(found), 128'd1);
        @(negedge clk);
        check_output("rst_m_cyc", 128'(m_cyc_o), 128'd0);
        check_output("rst_s_ack", 128'(s_ack_o), 128'd0);
        rst = 1'b0;

        // Normal request after reset
        clear_slave(0, -1, -1);
        apply_stimulus(32'h1000, '0, 1'b0, 16'hFFFF, lat, ack, err, rty, rdat, resp_after, cyc_after);
        check_output("post_rst_lat", 128'(lat), 128'd5);
        check_output("post_rst_dat", rdat, 128'h000000A3_000000A2_000000A1_000000A0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
